seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector with runtime-programmable pattern and mask, selectable overlapping or non-overlapping matching, input qualification and a saturating match counter. It is the next-generation replacement for the fixed single-pattern 101010 detector. It sits on a one-bit serial stream and produces a one-cycle match pulse plus a running match count for status readout.

## Interface
Parameters:
- N, 6: pattern length in bits (2..32).
- PATTERN, 6'b101010: reset value of the pattern register. PATTERN[N-1] is the oldest (first-received) bit; PATTERN[0] is the newest.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only on edges where x_valid=1.
- cfg_we  in  1  load cfg_pattern/cfg_mask on this edge.
- cfg_pattern  in  N  new pattern, same bit order as PATTERN.
- cfg_mask  in  N  per-bit compare enable (1 = compare, 0 = don't care).
- cnt_clr  in  1  clear match_count and cnt_sat.
- y  out  1  registered match pulse.
- match_count  out  CNT_W  number of matches since reset or clear; saturating.
- cnt_sat  out  1  sticky; set when match_count is at its maximum and a further match occurs.

## Operation
- State:
  - hist[N-1:0]: shift register of accepted bits.
  - fill: 0..N count of valid history bits.
  - pat_q, mask_q: pattern and mask registers.
  - match_count, cnt_sat.
- Accepted bit (x_valid=1, cfg_we=0): hist_next = {hist[N-2:0], x}; fill_next = min(fill+1, N).
- Match condition, evaluated on hist_next/fill_next: fill_next==N and ((hist_next ^ pat_q) & mask_q)==0.
- On a match:
  - y is 1 in the following cycle.
  - match_count increments. If match_count is already 2^CNT_W-1 it holds and cnt_sat is set.
  - If OVERLAP=0, fill is forced to 0 (hist contents irrelevant), so the next match needs N fresh bits.
  - If OVERLAP=1, fill stays at N.
- No match when x_valid=0. hist, fill and y=0 then; y is never held high for more than one cycle per accepted bit.
- cfg_we=1: pat_q←cfg_pattern, mask_q←cfg_mask, fill←0. Any x_valid on the same edge is discarded and y←0. match_count is unaffected.
- mask_q all zero: every accepted bit with fill_next==N matches.
- cnt_clr=1: match_count←0, cnt_sat←0. If a match occurs on the same edge, the clear wins and the count becomes 0. y still pulses.
- Priority: reset > cfg_we > x_valid. cnt_clr is independent of cfg_we.

## Timing
- Reset values: y=0, match_count=0, cnt_sat=0, hist=0, fill=0, pat_q=PATTERN, mask_q=all ones.
- Reset asserted mid-stream clears all of the above on that edge. Partial history is lost, and the first match after release needs N accepted bits.
- Latency: the completing bit is sampled at edge k. y=1 and match_count is updated in the cycle after edge k, and y drops at edge k+1 unless edge k+1 completes another match.
- Back-to-back matches (OVERLAP=1, pattern with period p<N, x_valid continuous) give y pulses every p cycles. With p=1 (e.g. all-ones), y stays high continuously.
- Gaps in x_valid stretch time but do not alter matching.
- A new configuration is effective for the first bit accepted after the cfg_we edge.

## Test plan
- Default config, OVERLAP=1, continuous valid, stream 1,0,1,0,1,0,1,0,1,0,1,0 → y pulses after bits 6, 8, 10, 12; match_count=4.
- Same stream with OVERLAP=0 → y pulses after bits 6 and 12 only; match_count=2.
- Stream 1,0,1,0,1,0 with x_valid low for 3 cycles between each bit → exactly one y pulse, one cycle after the 6th accepted bit.
- Load cfg_pattern=6'b110011 with cfg_mask=6'b111100, then stream 1,1,0,0,1,0 → match (low 2 bits are don't-care); stream 1,1,1,0,1,1 → no match. Also drive x_valid=1 on the cfg_we edge → that bit is ignored.
- CNT_W=2: 5 matches → match_count=3, cnt_sat=1. Then cnt_clr → match_count=0, cnt_sat=0.
- After 5 bits of 10101 assert reset for one edge, then send 0 → no y. Then send 101010 → y after the 6th bit.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector for a one-bit stream. The pattern and a per-bit
// compare mask can be loaded at runtime. Matching can overlap, or the history
// can restart after every match. A saturating counter records how many
// matches have occurred since reset or the last clear.
//
// Parameters
//   N        pattern length in bits (2..32)
//   PATTERN  reset value of the pattern register; bit N-1 is the oldest bit
//   OVERLAP  1 = overlapping matches, 0 = history restarts after each match
//   CNT_W    width of the match counter
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   x            in   serial data bit
//   x_valid      in   x is accepted only when this is high
//   cfg_we       in   load cfg_pattern / cfg_mask, restart history
//   cfg_pattern  in   new pattern (same bit order as PATTERN)
//   cfg_mask     in   per-bit compare enable (1 = compare, 0 = don't care)
//   cnt_clr      in   clear match_count and cnt_sat
//   y            out  registered one-cycle match pulse
//   match_count  out  saturating number of matches
//   cnt_sat      out  sticky: a match arrived while the counter was full
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N       = 6,
    parameter logic [N-1:0]   PATTERN = 6'b101010,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_we,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [N-1:0]     cfg_mask,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    // The fill counter must be able to hold the value N itself.
    localparam int                 FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(N);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N-1:0]      r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [N-1:0]      r_pat;
    logic [N-1:0]      r_mask;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat;
    logic              r_y;

    // -------------------------------------------------------------------------
    // Next-history view used for the match decision
    // -------------------------------------------------------------------------
    logic              w_accept;
    logic [N-1:0]      w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    logic [N-1:0]      w_bit_miss;
    logic              w_window_full;
    logic              w_match;

    // A configuration write discards any data bit presented on the same edge.
    assign w_accept    = x_valid & ~cfg_we;
    assign w_hist_next = {r_hist[N-2:0], x};
    assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);

    // Per-bit compare: a bit only counts as a miss when the mask enables it.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cmp
            assign w_bit_miss[gi] = r_mask[gi] & (w_hist_next[gi] ^ r_pat[gi]);
        end
    endgenerate

    assign w_window_full = (w_fill_next == FILL_FULL);
    assign w_match       = w_accept & w_window_full & ~(|w_bit_miss);

    // -------------------------------------------------------------------------
    // History, configuration and match pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_mask <= '1;
            r_y    <= 1'b0;
        end else if (cfg_we) begin
            // New configuration applies to the first bit accepted afterwards;
            // the old history is invalidated by zeroing the fill count.
            r_pat  <= cfg_pattern;
            r_mask <= cfg_mask;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (x_valid) begin
            r_hist <= w_hist_next;
            // Non-overlapping mode needs N fresh bits after every match.
            if (w_match && !OVERLAP) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
            r_y    <= w_match;
        end else begin
            r_y    <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating match counter. The clear is independent of cfg_we and wins
    // over a match on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (cnt_clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_match) begin
            if (r_count == CNT_MAX) begin
                r_sat   <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign y           = r_y;
    assign match_count = r_count;
    assign cnt_sat     = r_sat;

endmodule
